// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RAM_DEPTH  = 1024;
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/mem_stream_fifo.sv
// First-word-fall-through FIFO with occupancy count. When empty, the incoming
// word is presented directly at the head, so a same-cycle pop needs no storage.
module mem_stream_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_empty = (r_count == '0);
    // A word that arrives into an empty FIFO and is taken in the same cycle bypasses storage.
    assign w_push  = i_wr & ~(w_empty & i_rd);
    assign w_pop   = i_rd & ~w_empty;

    assign o_valid = ~w_empty | i_wr;
    assign o_data  = !w_empty ? r_mem[r_rptr] : (i_wr ? i_wdata : '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Avalon-MM read master streaming a block of RAM words out with credit-based flow control.
// Optional MEM_STREAM_READER_LOOP_EN: restart the block while `loop` is held high.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_done;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W:0]   w_rem_nxt;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_occ;
    logic              w_hs;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_wrap;
    logic              w_drained;

`ifdef MEM_STREAM_READER_LOOP_EN
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
`else
    logic              w_unused_loop;
    assign w_unused_loop = loop;
`endif

    mem_stream_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (r_inflight),
        .i_wdata (m_readdata),
        .i_rd    (w_hs),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    assign w_hs  = out_valid & out_ready;
    // Occupancy includes the read in flight; credits remain while it is below the depth.
    assign w_occ = w_count + CNT_W'(r_inflight);

    assign w_issue      = (r_state == ST_RUN) && (r_remaining != '0) && (w_occ < CNT_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_remaining == (ADDR_W+1)'(1));
    // Everything left is the word leaving this cycle, if any.
    assign w_drained    = (w_occ == CNT_W'(w_hs));

`ifdef MEM_STREAM_READER_LOOP_EN
    assign w_wrap     = w_last_issue & loop;
    assign w_addr_nxt = w_wrap ? r_base : r_addr + ADDR_W'(1);
    assign w_rem_nxt  = w_wrap ? r_len  : r_remaining - (ADDR_W+1)'(1);
`else
    assign w_wrap     = 1'b0;
    assign w_addr_nxt = r_addr + ADDR_W'(1);
    assign w_rem_nxt  = r_remaining - (ADDR_W+1)'(1);
`endif

    assign m_address    = r_addr;
    assign m_chipselect = w_issue;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_nxt = (length == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (w_last_issue && !w_wrap)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drained)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
`ifdef MEM_STREAM_READER_LOOP_EN
            r_base      <= '0;
            r_len       <= '0;
`endif
        end else begin
            r_inflight <= w_issue;
            r_done     <= (r_state == ST_DRAIN) && w_drained;
            if (r_state == ST_IDLE && start) begin
                r_addr      <= base_addr;
                r_remaining <= length;
`ifdef MEM_STREAM_READER_LOOP_EN
                r_base      <= base_addr;
                r_len       <= length;
`endif
            end else if (w_issue) begin
                r_addr      <= w_addr_nxt;
                r_remaining <= w_rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: expected words queued at start, popped on handshakes.
module tb_mem_stream_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          loop = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] m_readdata = '0;
    logic          busy, done, m_chipselect, m_write, m_clken, out_valid;
    logic [AW-1:0] m_address;
    logic [3:0]    m_byteenable;
    logic [DW-1:0] out_data;

    mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .loop         (loop),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [1024];
    always @(posedge clk) if (m_chipselect) m_readdata <= ram[m_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    int cs_cnt, cs_stall, done_cnt, done_cyc, first_hs, last_hs, st_cyc, a10;
    logic [AW-1:0] last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_chipselect) begin
                cs_cnt++;
                addr_q.push_back(m_address);
                last_addr = m_address;
                if (!out_ready) cs_stall++;
                if (m_address == 10) a10++;
            end
            if (out_valid && out_ready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
                else chk("stream_data", out_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        cs_cnt = 0; cs_stall = 0; done_cnt = 0; done_cyc = -1;
        first_hs = -1; last_hs = -1; a10 = 0;
        addr_q.delete();
    endtask

    task automatic do_start(input int b, input int len);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); length = (AW+1)'(len); st_cyc = cyc;
        for (int i = 0; i < len; i++) exp_q.push_back(ram[(b + i) % 1024]);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); length = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int d0, n;
        for (int k = 0; k < 1024; k++) ram[k] = DW'(k);
        clear_stats();

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_write", m_write, 0);
        chk("rst_be", m_byteenable, 4'hF);
        chk("rst_clken", m_clken, 1);
        @(posedge clk); #1 reset_n = 1'b1;

        // basic transfer
        clear_stats();
        do_start(16, 4);
        wait_done(50);
        chk("first_word_lat", first_hs, st_cyc + 2);
        chk("no_bubbles", last_hs - first_hs, 3);
        chk("done_after_last", done_cyc, last_hs + 1);
        chk("basic_cs", cs_cnt, 4);
        chk("busy_low", busy, 0);

        // backpressure, plus a start while busy that must be ignored
        clear_stats();
        out_ready = 1'b0;
        do_start(0, 10);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; base_addr = 500; length = 5;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(100);
        chk("stall_cs", cs_stall, 4);
        chk("bp_cs_total", cs_cnt, 10);

        // wrap-around
        clear_stats();
        do_start(1022, 4);
        wait_done(50);
        chk("wrap_n", addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < addr_q.size()) chk("wrap_addr", addr_q[i], (1022 + i) % 1024);

        // length 0
        clear_stats();
        do_start(7, 0);
        wait_done(20);
        chk("len0_done_lat", done_cyc, st_cyc + 2);
        chk("len0_no_reads", cs_cnt, 0);

        // full RAM from base 5
        clear_stats();
        do_start(5, 1024);
        wait_done(1200);
        chk("full_cs", cs_cnt, 1024);
        chk("full_last_addr", last_addr, 4);

        // random backpressure
        clear_stats();
        do_start(300, 20);
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        chk("rand_done", done_cnt, d0 + 1);
        chk("rand_queue", exp_q.size(), 0);

        // reset mid-transfer
        clear_stats();
        do_start(0, 100);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cs", m_chipselect, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", m_address, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_be", m_byteenable, 4'hF);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("no_done_after_rst", done_cnt, d0);
        do_start(0, 2);
        wait_done(20);

`ifdef MEM_STREAM_READER_LOOP_EN
        clear_stats();
        loop = 1'b1;
        do_start(8, 3);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 3; i++) exp_q.push_back(ram[8 + i]);
        n = 0;
        while (a10 < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1 loop = 1'b0;
        wait_done(50);
        chk("loop_cs", cs_cnt, 9);
        chk("loop_single_done", done_cnt, 1);
`else
        clear_stats();
        loop = 1'b1;
        do_start(40, 3);
        wait_done(30);
        loop = 1'b0;
        chk("noloop_cs", cs_cnt, 3);
        chk("noloop_done", done_cnt, 1);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Avalon-MM read master and streaming front end for the 1024×32 single-port on-chip RAM. On `start` it reads a block of consecutive words from a base address and presents them on a valid/ready output stream, for example to feed an alarm tone/pattern player. A credit-based output FIFO means the RAM is never read faster than the consumer drains words, and no word is dropped or duplicated.

## Interface
- `ADDR_W`, 10, RAM word-address width (1024 words).
- `DATA_W`, 32, RAM/stream data width.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a transfer; sampled only in IDLE.
- `base_addr` in ADDR_W: first word address; captured on accepted `start`.
- `length` in ADDR_W+1: word count, 0..1024; captured on accepted `start`.
- `loop` in 1: restart at `base_addr` after the last word (only with `MEM_STREAM_READER_LOOP_EN`).
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last word is accepted downstream.
- `m_address` out ADDR_W: RAM word address.
- `m_chipselect` out 1: read strobe; one word per asserted cycle.
- `m_write` out 1: constant 0.
- `m_byteenable` out 4: constant 4'hF.
- `m_clken` out 1: constant 1.
- `m_readdata` in DATA_W: RAM data, valid exactly 1 cycle after the `m_chipselect` cycle.
- `out_data` out DATA_W: stream word.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer ready; a transfer occurs when `out_valid & out_ready`.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
  - IDLE: on `start`, capture `base_addr` and `length`, set `busy`, and go to RUN. If `length==0`, go straight to DRAIN.
  - RUN: issue a read whenever `remaining_issue != 0` and `credits > 0`. Go to DRAIN when the last read has been issued.
  - DRAIN: wait until there are no reads in flight and the FIFO is empty, then pulse `done`, clear `busy`, and return to IDLE.
- Credit rules:
  - `credits` = `FIFO_DEPTH` − FIFO occupancy − in-flight reads (0 or 1).
  - A read consumes 1 credit. An output handshake returns 1 credit. Both can happen in the same cycle.
- Read return: the word returning from the RAM is written into the FIFO unconditionally. Overflow is impossible by the credit rule.
- Address arithmetic: `m_address` increments modulo 2^ADDR_W. Reading from base 1020 with length 8 reads 1020..1023, then 0..3.
- `start` while busy is ignored. `base_addr`/`length` changes while busy have no effect.
- `out_data` is the FIFO head and is stable while `out_valid & ~out_ready`.
- Reset (including mid-transfer):
  - State returns to IDLE and the FIFO and credits are cleared.
  - All outputs go to 0, except `m_byteenable`=4'hF and `m_clken`=1.
  - In-flight data is discarded.

## Timing
- Start to first read: `m_chipselect` is high in the cycle after `start`.
- Start to first word: `out_valid` is high in the cycle after that, i.e. 2 cycles after `start`.
- Steady state with `out_ready` held high: 1 word per cycle, no bubbles.
- Stall: when `out_ready` is low, reads stop once `credits` reaches 0. At most `FIFO_DEPTH` words are outstanding.
- `done` is asserted in the cycle after the final output handshake, together with `busy` falling.
- `length==0`: `done` pulses 2 cycles after `start`, with no `m_chipselect`.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `MEM_STREAM_READER_LOOP_EN` defined:
  - When the last read is issued and `loop`=1, the address reloads `base_addr` and the issue count reloads `length`. The FSM stays in RUN and does not pulse `done`.
  - `loop` is sampled at each wrap point. Deasserting it ends the transfer normally after the current pass.
  - With `length==0`, `loop` is ignored.
- Not defined: the `loop` port exists but is ignored. Every transfer ends with `done`.

## Structure
- Package `mem_stream_pkg`: FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DRAIN`), `RAM_DEPTH`=1024, `RD_LATENCY`=1.
- One sub-module, `mem_stream_fifo`: a synchronous FIFO of `FIFO_DEPTH`×`DATA_W` with first-word-fall-through, count output, and asynchronous active-low reset.

## Test plan
- Basic transfer: RAM holds k at address k; base 16, length 4, `out_ready`=1. The stream must output 16,17,18,19 in consecutive cycles, the first at `start`+2, with `done` one cycle after the last word.
- Backpressure: base 0, length 10, `out_ready` low for 8 cycles after `start`. Exactly 4 `m_chipselect` cycles occur during the stall. Once released, words 0..9 arrive in order with no loss or duplicates.
- Wrap-around: base 1022, length 4. The sequence of `m_address` values must be 1022,1023,0,1, and the output data must match those addresses.
- Boundary lengths: length 0 gives `done` at `start`+2 with no reads. Length 1024 from base 5 reads every address exactly once and ends at address 4.
- Reset mid-operation: assert `reset_n`=0 during a length-100 transfer. Outputs clear immediately and no `done` is pulsed. After reset, a new transfer with base 0, length 2 streams 0,1 correctly.
- Loop mode (macro defined): base 8, length 3, `loop`=1 for two passes, then drop `loop`. The stream must be 8,9,10,8,9,10,8,9,10 with a single `done` at the end.
